comp_serial_rsp: RTL and testbench
==================================

COMP_SERIAL_RSP -- requirements
Module: comp_serial_rsp

Interface
REQ-001 Parameter: none; the operand width is fixed at 32 bits and the slice width at 4 bits (8 slices).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  requester presents an operand pair.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  32  operand A, sampled only on the accept edge.
REQ-007 b  input  32  operand B, sampled only on the accept edge.
REQ-008 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled on the accept edge.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 eq  output  1  A == B.
REQ-012 lt  output  1  A < B.
REQ-013 gt  output  1  A > B.
REQ-014 steps  output  4  number of slices examined for this result, 1..8.

Function
REQ-015 The block SHALL implement the FSM states IDLE, CMP and DONE.
REQ-016 IDLE: in_ready=1; when in_valid&&in_ready, SHALL capture a, b and signed_mode, set the slice index to 7, clear steps, and go to CMP.
REQ-017 in_ready SHALL be 0 in CMP and DONE; in_valid in those states SHALL be ignored, and a/b changes SHALL have no effect.
REQ-018 CMP: each cycle SHALL compare one 4-bit slice, MSB-first (bits [4i+3:4i] for i = 7 down to 0), and increment steps.
REQ-019 Signed mode: bit 31 of both captured operands SHALL be inverted before the slice-7 compare; the other slices are unchanged.
REQ-020 A slice mismatch SHALL set lt or gt from the unsigned slice compare, end the operation early, and go to DONE.
REQ-021 If slice 0 compares equal, the block SHALL set eq and go to DONE.
REQ-022 Latency: with the accept edge at T, out_valid SHALL rise after edge T+steps. The minimum is 1 cycle; the maximum is 8 cycles.
REQ-023 DONE: out_valid=1; eq, lt, gt and steps SHALL be held stable until out_valid&&out_ready.
REQ-024 On that handshake the block SHALL return to IDLE, with in_ready=1 on the next cycle; there is no accept in the same cycle as the handshake.
REQ-025 When out_valid=1, exactly one of eq/lt/gt SHALL be 1.
REQ-026 When out_valid=0, eq, lt and gt SHALL all be 0.
REQ-027 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-028 When rst_n=0 the block SHALL, immediately and regardless of clk: state=IDLE, in_ready=1, out_valid=0, eq=lt=gt=0, steps=0, captured operands cleared.
REQ-029 Reset during CMP or DONE SHALL abort the operation without emitting a result.
REQ-030 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-031 Unsigned, a=b=0x12345678 -> eq=1, steps=8, out_valid 8 cycles after accept.
REQ-032 Unsigned, a=0x80000000, b=0x00000001 -> gt=1, steps=1. Same operands with signed_mode=1 -> lt=1, steps=1.
REQ-033 Unsigned, a=0x12345670, b=0x12345678 -> lt=1, steps=8. Unsigned, a=0x12F45678, b=0x12345678 -> gt=1, steps=3.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling a, b and in_valid -> out_valid, eq/lt/gt and steps stable, in_ready=0. Raise out_ready -> in_ready=1 on the next cycle.
REQ-035 Assert rst_n=0 mid-CMP (a=b=0xFFFFFFFF, after 3 cycles) -> all outputs 0 and in_ready=1 without a clock edge. After release, a=5, b=7 unsigned -> lt=1, steps=8.
REQ-036 Back-to-back: 20 random pairs plus equal pairs 0x12345678, out_ready held at 1 -> every result matches a reference compare and exactly one result per accept.

Source files
------------

// File: rtl/comp_serial_rsp_if.sv
// ---------------------------------------------------------------------------
// comp_serial_rsp_if : request/response handshake bundle for comp_serial_rsp
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface comp_serial_rsp_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        signed_mode;
  logic        out_valid;
  logic        out_ready;
  logic        eq;
  logic        lt;
  logic        gt;
  logic [3:0]  steps;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, eq, lt, gt, steps
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, eq, lt, gt, steps
  );
endinterface

`default_nettype wire

// File: rtl/comp_serial_rsp.sv
// ---------------------------------------------------------------------------
// comp_serial_rsp : 32-bit serial magnitude comparator, one 4-bit slice per
//                   cycle MSB-first with early exit; signed or unsigned.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module comp_serial_rsp (
  input  wire                  clk,
  input  wire                  rst_n,
  comp_serial_rsp_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_sgn;
  logic [2:0]  r_idx;
  logic [3:0]  r_steps;
  logic        r_eq;
  logic        r_lt;
  logic        r_gt;

  logic        w_accept;
  logic        w_release;
  logic [31:0] w_a_eff;
  logic [31:0] w_b_eff;
  logic [4:0]  w_lsb;
  logic [3:0]  w_sa;
  logic [3:0]  w_sb;
  logic        w_mismatch;

  assign w_accept  = (r_state == S_IDLE) && bus.in_valid;
  assign w_release = (r_state == S_DONE) && bus.out_ready;

  // Flipping the sign bits maps two's-complement order onto unsigned order,
  // so only slice 7 sees a difference between the two modes.
  assign w_a_eff    = {r_a[31] ^ r_sgn, r_a[30:0]};
  assign w_b_eff    = {r_b[31] ^ r_sgn, r_b[30:0]};
  assign w_lsb      = {r_idx, 2'b00};
  assign w_sa       = w_a_eff[w_lsb +: 4];
  assign w_sb       = w_b_eff[w_lsb +: 4];
  assign w_mismatch = (w_sa != w_sb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_state_nxt = S_CMP;
        end
      end
      S_CMP: begin
        if (w_mismatch || (r_idx == 3'd0)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_sgn   <= 1'b0;
      r_idx   <= 3'd0;
      r_steps <= 4'd0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
      r_gt    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a     <= bus.a;
        r_b     <= bus.b;
        r_sgn   <= bus.signed_mode;
        r_idx   <= 3'd7;
        r_steps <= 4'd0;
      end else if (r_state == S_CMP) begin
        r_steps <= r_steps + 4'd1;
        r_idx   <= r_idx - 3'd1;
        if (w_mismatch) begin
          r_lt <= (w_sa < w_sb);
          r_gt <= (w_sa > w_sb);
        end else if (r_idx == 3'd0) begin
          r_eq <= 1'b1;
        end
      end else if (w_release) begin
        r_eq    <= 1'b0;
        r_lt    <= 1'b0;
        r_gt    <= 1'b0;
        r_steps <= 4'd0;
      end
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.eq        = r_eq;
  assign bus.lt        = r_lt;
  assign bus.gt        = r_gt;
  assign bus.steps     = r_steps;

endmodule

`default_nettype wire

// File: tb/tb_comp_serial_rsp.sv
// ---------------------------------------------------------------------------
// tb_comp_serial_rsp : directed + random self-checking bench for comp_serial_rsp
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_comp_serial_rsp;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;
  int   n_acc;
  int   n_res;

  comp_serial_rsp_if bus ();

  comp_serial_rsp dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) n_acc++;
      if (bus.out_valid && bus.out_ready) n_res++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: first differing nibble from the top decides the step count.
  function automatic logic [3:0] ref_steps(input logic [31:0] x, input logic [31:0] y);
    for (int i = 7; i >= 0; i--) begin
      if (x[i*4 +: 4] != y[i*4 +: 4]) return 4'(8 - i);
    end
    return 4'd8;
  endfunction

  // Issue one operand pair, measure latency, check result, optionally release.
  task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic sm, input logic xeq, input logic xlt, input logic xgt,
                        input logic [3:0] xsteps, input bit release_it);
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (!bus.in_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    bus.a = va;
    bus.b = vb;
    bus.signed_mode = sm;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cnt = 0;
    while (!bus.out_valid && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk({tag, "_lat"}, 32'(cnt), 32'(xsteps));
    chk({tag, "_res"}, {28'd0, bus.eq, bus.lt, bus.gt, bus.out_valid},
        {28'd0, xeq, xlt, xgt, 1'b1});
    chk({tag, "_steps"}, 32'(bus.steps), 32'(xsteps));
    if (release_it) begin
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk({tag, "_idle"}, {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs, xeq, xlt, xgt;
    logic [3:0]  xs, hs;
    logic [2:0]  hres;
    int          acc0, res0;

    n_chk = 0; n_bad = 0; n_acc = 0; n_res = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
    bus.signed_mode = 1'b0; bus.out_ready = 1'b0;
    #12;
    chk("reset_out", {25'd0, bus.in_ready, bus.out_valid, bus.eq, bus.lt, bus.gt, bus.steps == 4'd0},
        {25'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;

    run_op("eq_full",  32'h12345678, 32'h12345678, 1'b0, 1, 0, 0, 4'd8, 1);
    run_op("msb_uns",  32'h80000000, 32'h00000001, 1'b0, 0, 0, 1, 4'd1, 1);
    run_op("msb_sgn",  32'h80000000, 32'h00000001, 1'b1, 0, 1, 0, 4'd1, 1);
    run_op("lsb_lt",   32'h12345670, 32'h12345678, 1'b0, 0, 1, 0, 4'd8, 1);
    run_op("mid_gt",   32'h12F45678, 32'h12345678, 1'b0, 0, 0, 1, 4'd3, 1);
    run_op("sgn_neg",  32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 0, 0, 1, 4'd8, 1);

    // Backpressure: result must hold while inputs churn
    run_op("bp", 32'h00F00000, 32'h00100000, 1'b0, 0, 0, 1, 4'd3, 0);
    hres = {bus.eq, bus.lt, bus.gt};
    hs   = bus.steps;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.a = $urandom; bus.b = $urandom; bus.in_valid = ~bus.in_valid;
      @(posedge clk);
      #1;
      chk("bp_hold", {22'd0, bus.out_valid, bus.in_ready, bus.eq, bus.lt, bus.gt, bus.steps, 1'b0},
          {22'd0, 1'b1, 1'b0, hres, hs, 1'b0});
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("bp_release", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);

    // Reset in the middle of a comparison
    @(negedge clk);
    bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF; bus.signed_mode = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {24'd0, bus.in_ready, bus.out_valid, bus.eq, bus.lt, bus.gt, bus.steps},
        {24'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 32'd5, 32'd7, 1'b0, 0, 1, 0, 4'd8, 1);

    // Back-to-back with the consumer always ready
    acc0 = n_acc; res0 = n_res;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 22; i++) begin
      if (i < 20) begin
        ra = $urandom; rb = (i % 4 == 0) ? (ra ^ (32'h1 << $urandom_range(31, 0))) : $urandom;
        rs = 1'($urandom_range(1, 0));
      end else begin
        ra = 32'h12345678; rb = 32'h12345678; rs = 1'(i & 1);
      end
      xeq = (ra == rb);
      xlt = rs ? ($signed(ra) < $signed(rb)) : (ra < rb);
      xgt = !xeq && !xlt;
      xs  = ref_steps(ra, rb);
      run_op("b2b", ra, rb, rs, xeq, xlt, xgt, xs, 0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("b2b_count", 32'(n_res - res0), 32'(n_acc - acc0));
    chk("b2b_total", 32'(n_res - res0), 32'd22);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
